// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter: round-robin sharing of one AXI4-Lite master port among NUM_REQ requesters
module axil_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]          req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ISSUE_W, ISSUE_R, WAIT_B, WAIT_R, RESP} state_t;

    state_t                state, state_nx;
    logic [GW-1:0]         last_grant, grant, cur, idx;
    logic                  any_req, aw_done, w_done;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [3:0]            cap_wstrb;

    assign M_AXI_AWADDR = cap_addr;
    assign M_AXI_ARADDR = cap_addr;
    assign M_AXI_WDATA  = cap_wdata;
    assign M_AXI_WSTRB  = cap_wstrb;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign busy         = (state != IDLE);

    // rotating priority search; scanning far-to-near lets the nearest valid requester win
    always_comb begin
        grant   = last_grant;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = GW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nx;
    end

    // next state and handshake outputs; all outputs derive from registers, never from M_AXI inputs
    always_comb begin
        state_nx      = state;
        req_ready     = '0;
        rsp_valid     = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            IDLE: if (any_req && ARESETN) begin
                req_ready[grant] = 1'b1;
                state_nx         = req_write[grant] ? ISSUE_W : ISSUE_R;
            end
            ISSUE_W: begin
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) state_nx = WAIT_B;
            end
            ISSUE_R: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_nx = WAIT_R;
            end
            WAIT_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_nx = RESP;
            end
            WAIT_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_nx = RESP;
            end
            RESP: begin
                rsp_valid[cur] = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // request capture, channel-done flags and response latching
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_grant <= GW'(NUM_REQ - 1);
            cur        <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rsp_rdata  <= '0;
            rsp_resp   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant <= grant;
                cur        <= grant;
                cap_addr   <= req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
                cap_wdata  <= req_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
                cap_wstrb  <= req_wstrb[grant*4 +: 4];
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end
            if (state == ISSUE_W && M_AXI_AWREADY) aw_done <= 1'b1;
            if (state == ISSUE_W && M_AXI_WREADY)  w_done  <= 1'b1;
            if (state == WAIT_B && M_AXI_BVALID) begin
                rsp_rdata <= '0;
                rsp_resp  <= M_AXI_BRESP;
            end
            if (state == WAIT_R && M_AXI_RVALID) begin
                rsp_rdata <= M_AXI_RDATA;
                rsp_resp  <= M_AXI_RRESP;
            end
        end
    end
endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb_axil_req_arbiter: directed self-checking bench with a small AXI4-Lite slave model
module tb_axil_req_arbiter;
    localparam int N = 4;

    logic           ACLK, ARESETN;
    logic [N-1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N*4-1:0] req_wstrb;
    logic [31:0]    rsp_rdata;
    logic [1:0]     rsp_resp;
    logic           busy;
    logic [31:0]    AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]     AWPROT, ARPROT;
    logic [3:0]     WSTRB;
    logic           AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic           ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]     BRESP, RRESP;

    int checks = 0, failures = 0;
    logic err_mode = 1'b0, b_hold = 1'b0;
    logic got_aw, got_w;
    logic [31:0] aw_l, wd_l;
    logic [31:0] mem [4];
    logic snap_awv, snap_wv;
    logic [31:0] snap_aw, snap_wd;
    logic [3:0] snap_ws;

    axil_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // slave: B one cycle after both AW and W are done, R one cycle after AR
    always @(posedge ACLK or negedge ARESETN) begin : slave
        logic aw_hs, w_hs;
        logic [31:0] wa, wd;
        if (!ARESETN) begin
            BVALID <= 1'b0; RVALID <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            BRESP <= 2'b00; RRESP <= 2'b00; RDATA <= 32'h0; aw_l <= 32'h0; wd_l <= 32'h0;
        end else begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            wa    = aw_hs ? AWADDR : aw_l;
            wd    = w_hs ? WDATA : wd_l;
            if (aw_hs) begin aw_l <= AWADDR; got_aw <= 1'b1; end
            if (w_hs)  begin wd_l <= WDATA;  got_w  <= 1'b1; end
            if ((got_aw || aw_hs) && (got_w || w_hs) && !b_hold && !BVALID) begin
                mem[wa[3:2]] <= wd;
                BVALID <= 1'b1; BRESP <= 2'b00; got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                RVALID <= 1'b1;
                RDATA  <= err_mode ? 32'hDEADBEEF : mem[ARADDR[3:2]];
                RRESP  <= err_mode ? 2'b10 : 2'b00;
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic transact(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rd, output logic [1:0] rs);
        logic acc, got;
        rd = 'x; rs = 'x; lat = -1; acc = 1'b0; got = 1'b0;
        req_write[i] = wr; req_addr[i*32 +: 32] = a; req_wdata[i*32 +: 32] = d;
        req_wstrb[i*4 +: 4] = 4'hF; req_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge ACLK);
            acc = req_ready[i];
        end
        check("accept", 64'(acc), 64'd1);
        if (!acc) begin
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge ACLK); #1;
        req_valid[i] = 1'b0;
        lat = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge ACLK);
            lat++;
            if (lat == 1) begin
                snap_awv = AWVALID; snap_wv = WVALID; snap_aw = AWADDR; snap_wd = WDATA; snap_ws = WSTRB;
            end
            if (rsp_valid[i]) begin
                got = 1'b1; rd = rsp_rdata; rs = rsp_resp;
            end
        end
        if (!got) lat = -1;
        @(posedge ACLK); #1;
    endtask

    initial begin
        int lat, e, g;
        logic [31:0] rd;
        logic [1:0] rs;
        logic ok, seen;
        logic awv [1:6];
        logic wv [1:6];
        logic br [1:6];
        logic rv [1:6];
        int order [6] = '{0, 1, 2, 3, 0, 1};
        ARESETN = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        AWREADY = 1'b1; WREADY = 1'b1; ARREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 req_valid[0] = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_axi_valid_ready", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 64'd0);
        check("rst_rsp_data", 64'({rsp_rdata, rsp_resp}), 64'd0);
        req_valid = '0;
        @(negedge ACLK) ARESETN = 1'b1;
        @(posedge ACLK); #1;

        transact(0, 1'b1, 32'h0, 32'h1, lat, rd, rs);
        check("wr_latency", 64'(lat), 64'd3);
        check("wr_awvalid_wvalid", 64'({snap_awv, snap_wv}), 64'b11);
        check("wr_awaddr", 64'(snap_aw), 64'h0);
        check("wr_wdata", 64'(snap_wd), 64'h1);
        check("wr_wstrb", 64'(snap_ws), 64'hF);
        check("wr_resp", 64'(rs), 64'd0);
        check("wr_rdata_zero", 64'(rd), 64'd0);

        for (int j = 0; j < 4; j++) begin
            transact(1, 1'b1, 32'(j * 4), 32'(j + 1), lat, rd, rs);
            check("wb_write_resp", 64'(rs), 64'd0);
        end
        for (int j = 0; j < 4; j++) begin
            transact(1, 1'b0, 32'(j * 4), 32'h0, lat, rd, rs);
            check("wb_read_data", 64'(rd), 64'(j + 1));
            check("wb_read_resp", 64'(rs), 64'd0);
            if (j == 0) check("rd_latency", 64'(lat), 64'd3);
        end

        err_mode = 1'b1;
        transact(2, 1'b0, 32'h8, 32'h0, lat, rd, rs);
        err_mode = 1'b0;
        check("err_rdata", 64'(rd), 64'hDEADBEEF);
        check("err_resp", 64'(rs), 64'd2);

        WREADY = 1'b0;
        req_write[0] = 1'b1; req_addr[31:0] = 32'hC; req_wdata[31:0] = 32'h55; req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge ACLK);
            ok = req_ready[0];
        end
        check("skew_accept", 64'(ok), 64'd1);
        @(posedge ACLK); #1;
        req_valid[0] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge ACLK);
            awv[c] = AWVALID; wv[c] = WVALID; br[c] = BREADY; rv[c] = rsp_valid[0];
            @(posedge ACLK); #1;
            if (c == 3) WREADY = 1'b1;
        end
        check("skew_awvalid_c1", 64'(awv[1]), 64'd1);
        check("skew_awvalid_c2", 64'(awv[2]), 64'd0);
        check("skew_wvalid_c4", 64'(wv[4]), 64'd1);
        check("skew_wvalid_c5", 64'(wv[5]), 64'd0);
        check("skew_bready_c4", 64'(br[4]), 64'd0);
        check("skew_bready_c5", 64'(br[5]), 64'd1);
        check("skew_rsp_c6", 64'(rv[6]), 64'd1);

        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        req_write = '0; req_addr = '0; req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            e = order[k]; g = -1;
            for (int n = 0; n < 50 && g < 0; n++) begin
                @(negedge ACLK);
                for (int b = 0; b < N; b++) if (req_ready[b]) g = b;
            end
            check("fair_grant", 64'(req_ready), 64'(4'b0001 << e));
            if (g < 0) break;
            @(posedge ACLK); #1;
            req_valid[g] = 1'b0;
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge ACLK);
                seen = rsp_valid[g];
            end
            check("fair_rsp", 64'(seen), 64'd1);
            @(posedge ACLK); #1;
            req_valid[g] = 1'b1;
        end
        req_valid = '0;
        repeat (6) @(posedge ACLK);
        #1;

        b_hold = 1'b1;
        req_write[1] = 1'b1; req_addr[63:32] = 32'h4; req_wdata[63:32] = 32'h99; req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge ACLK);
            ok = req_ready[1];
        end
        @(posedge ACLK); #1;
        req_valid[1] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge ACLK);
            ok = BREADY;
        end
        check("mid_in_wait_b", 64'(ok), 64'd1);
        #2 ARESETN = 1'b0;
        #1;
        check("mid_axi_cleared", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 64'd0);
        check("mid_busy_cleared", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge ACLK);
            seen = seen | (|rsp_valid);
        end
        b_hold = 1'b0;
        ARESETN = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge ACLK);
            seen = seen | (|rsp_valid);
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        @(posedge ACLK); #1;
        req_write = '0; req_valid = 4'b1001;
        #1;
        check("post_rst_prio_req0", 64'(req_ready), 64'b0001);
        req_valid = 4'b1000;
        #1;
        check("post_rst_req3_alone", 64'(req_ready), 64'b1000);
        @(posedge ACLK); #1;
        req_valid = '0;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge ACLK);
            seen = rsp_valid[3];
        end
        check("post_rst_req3_rsp", 64'(seen), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_req_arbiter.md
# axil_req_arbiter

Round-robin arbiter that shares a single AXI4-Lite master port between NUM_REQ local requesters. It sits in front of the Unified_Registers AXI4-Lite slave, alongside or in place of the bus master. Each requester issues single-beat read or write requests over a simple valid/ready port. The block serialises them, with one outstanding AXI transaction at a time, and returns the response to the originating requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 only)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester request valid; held until accepted
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flat; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flat write data
- req_wstrb  in  NUM_REQ*4  flat byte strobes
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the originating requester
- rsp_rdata  out  DATA_WIDTH  read data; valid while any rsp_valid bit is high
- rsp_resp  out  2  BRESP/RRESP of the completed transaction
- busy  out  1  high whenever state != IDLE
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master; AWPROT and ARPROT are tied to 3'b000

## Operation
- FSM states: IDLE, ISSUE_W, ISSUE_R, WAIT_B, WAIT_R, RESP.
- IDLE, any req_valid high:
  - Grant g is the first requester with req_valid high, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[g] pulses in this cycle.
  - Address, data, strobe and direction of g are captured into registers.
  - last_grant <= g.
  - Next state is ISSUE_W if the request is a write, otherwise ISSUE_R.
- ISSUE_W:
  - AWVALID and WVALID both rise on state entry.
  - Each channel drops independently on its own handshake; aw_done and w_done flags are latched.
  - Go to WAIT_B once both handshakes are done. AW and W handshaking in the same cycle is allowed.
- ISSUE_R: ARVALID high until ARREADY, then go to WAIT_R.
- WAIT_B: BREADY=1. On BVALID, latch BRESP and go to RESP.
- WAIT_R: RREADY=1. On RVALID, latch RDATA and RRESP and go to RESP.
- RESP:
  - rsp_valid[g] is high for exactly one cycle, driven with rsp_rdata (0 for writes) and rsp_resp.
  - Next state is IDLE.
- Responses are never back-pressured; requesters must sample rsp_valid in the pulse cycle.
- Requests arriving while busy are not accepted; they wait in IDLE arbitration with no loss.
- A requester that deasserts req_valid before being accepted is simply skipped.
- SLVERR and DECERR are passed through unchanged. The block does not retry.

## Timing
- Reset (ARESETN low) forces, asynchronously:
  - state IDLE;
  - all VALID/READY outputs, req_ready, rsp_valid and busy to 0;
  - rsp_rdata and rsp_resp to 0;
  - last_grant to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transaction abandons the transfer. No rsp_valid is issued, and the requester must re-request.
- Arbitration is combinational from req_valid in IDLE. req_ready is combinational, but the captured data is registered.
- Minimum write latency, with AWREADY=WREADY=1 and BVALID returned one cycle after:
  - cycle 0: accept;
  - cycle 1: AW/W handshake;
  - cycle 2: B handshake;
  - cycle 3: rsp_valid.
- Read minimum latency is identical via AR/R.
- Back-to-back throughput: a new accept is possible in the cycle after RESP, i.e. 4 cycles minimum per transaction.
- The AXI address, data and strobe outputs are stable from VALID rise until handshake.
- No combinational path exists from M_AXI inputs to M_AXI outputs.

## Test plan
- Single write: req0 writes addr 0x0, data 0x1, wstrb 0xF with zero-wait slave.
  - AWADDR=0x0, WDATA=0x1, WSTRB=0xF.
  - rsp_valid[0] 3 cycles after accept, rsp_resp=0.
- Write/readback: req1 writes 0x1..0x4 to 0x0/0x4/0x8/0xC, then reads all four.
  - rsp_rdata returns 0x1, 0x2, 0x3, 0x4 in order, each with resp OKAY.
- Fairness: all four req_valid held high, each re-asserted after rsp.
  - Grant order 0,1,2,3,0,1; no requester is granted twice while another waits.
- Channel skew: AWREADY in cycle 1, WREADY delayed to cycle 4.
  - AWVALID drops after cycle 1; WVALID is held until cycle 4.
  - BREADY is asserted only from cycle 5.
- Error: slave returns RRESP=2'b10 with RDATA=0xDEADBEEF for req2.
  - rsp_valid[2] with rsp_resp=2'b10 and rsp_rdata=0xDEADBEEF.
- Reset mid-operation: ARESETN dropped in WAIT_B.
  - All VALID/READY outputs go to 0 immediately and no rsp_valid is issued.
  - After release, a req3 request is granted first only if req0..req2 are idle.
